// File: rtl/sal_bank_timer.sv
// sal_bank_timer: per-bank DDR2 row-state and timing tracker for one bank.
// Latency: command flags are combinational from registered state; a command
//   issued in cycle N updates state/counters at N+1 (err_o also at N+1).
// Backpressure: none; the scheduler must honour the *_ok flags.
//
// Ports:
//   clk, rst               single clock, asynchronous active-high reset
//   t_rcd..t_wtp           bank timing parameters (quasi-static, TW bits)
//   act_i/rd_i/wr_i/pre_i/ref_i   commands issued to this bank this cycle
//   ra_i                   row address, captured with act_i
//   act_ok_o/rdwr_ok_o/pre_ok_o/ref_ok_o   per-command legality this cycle
//   open_o, open_ra_o      row open (OPENING/OPEN) and last activated row
//   err_o                  sticky illegal-command flag
//
// Build option: define SAL_BK_CMD_CHECK_EN to drop illegal commands and flag
// them on err_o. Without it err_o is tied low and commands are always applied,
// with simultaneous commands resolved by priority ref > pre > act > wr > rd.
module sal_bank_timer #(
  parameter int TW    = 8,
  parameter int ROW_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    t_rcd,
  input  logic [TW-1:0]    t_rp,
  input  logic [TW-1:0]    t_ras,
  input  logic [TW-1:0]    t_rfc,
  input  logic [TW-1:0]    t_rtp,
  input  logic [TW-1:0]    t_wtp,
  input  logic             act_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             pre_i,
  input  logic             ref_i,
  input  logic [ROW_W-1:0] ra_i,
  output logic             act_ok_o,
  output logic             rdwr_ok_o,
  output logic             pre_ok_o,
  output logic             ref_ok_o,
  output logic             open_o,
  output logic [ROW_W-1:0] open_ra_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    ST_CLOSED     = 3'd0,
    ST_OPENING    = 3'd1,
    ST_OPEN       = 3'd2,
    ST_CLOSING    = 3'd3,
    ST_REFRESHING = 3'd4
  } state_t;

  localparam logic [TW-1:0] CNT_ONE = TW'(1);

  // Saturating decrement. The same expression gives the load value for a
  // timing parameter: max(t,1)-1, so t=0 behaves like t=1.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    sat_dec = (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  function automatic logic [TW-1:0] cnt_max(input logic [TW-1:0] a,
                                            input logic [TW-1:0] b);
    cnt_max = (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [TW-1:0]    main_cnt_q, main_cnt_d;  // tRCD / tRP / tRFC depending on state
  logic [TW-1:0]    ras_cnt_q, ras_cnt_d;
  logic [TW-1:0]    rtp_cnt_q, rtp_cnt_d;
  logic [TW-1:0]    wtp_cnt_q, wtp_cnt_d;
  logic [ROW_W-1:0] open_ra_q, open_ra_d;

  // ---------------------------------------------------------------------
  // Legality flags
  // ---------------------------------------------------------------------
  logic main_zero;
  logic closed_like;
  logic act_ok;
  logic rdwr_ok;
  logic pre_ok;

  always_comb begin
    main_zero   = (main_cnt_q == '0);
    // A precharging/refreshing bank whose timer has expired accepts the same
    // commands as a closed bank; it just has not fallen back to CLOSED yet.
    closed_like = (state_q == ST_CLOSED) ||
                  (((state_q == ST_CLOSING) || (state_q == ST_REFRESHING)) && main_zero);
    act_ok      = closed_like;
    rdwr_ok     = (state_q == ST_OPEN) || ((state_q == ST_OPENING) && main_zero);
    pre_ok      = (state_q == ST_OPEN) && (ras_cnt_q == '0) &&
                  (rtp_cnt_q == '0) && (wtp_cnt_q == '0);
  end

  // ---------------------------------------------------------------------
  // Command selection
  // ---------------------------------------------------------------------
  logic do_act;
  logic do_rd;
  logic do_wr;
  logic do_pre;
  logic do_ref;

`ifdef SAL_BK_CMD_CHECK_EN
  logic [4:0] cmd_vec;
  logic       cmd_multi;
  logic       cmd_illegal;
  logic       err_q, err_d;

  always_comb begin
    cmd_vec     = {act_i, rd_i, wr_i, pre_i, ref_i};
    // More than one bit set: clearing the lowest set bit leaves something.
    cmd_multi   = |(cmd_vec & (cmd_vec - 5'd1));
    cmd_illegal = cmd_multi ||
                  (act_i && !act_ok) || (ref_i && !act_ok) ||
                  (rd_i  && !rdwr_ok) || (wr_i && !rdwr_ok) ||
                  (pre_i && !pre_ok);
    // Only a single legal command survives; anything else is dropped whole.
    do_act = act_i && !cmd_illegal;
    do_rd  = rd_i  && !cmd_illegal;
    do_wr  = wr_i  && !cmd_illegal;
    do_pre = pre_i && !cmd_illegal;
    do_ref = ref_i && !cmd_illegal;
    err_d  = err_q || cmd_illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  always_comb begin
    do_ref = ref_i;
    do_pre = pre_i && !ref_i;
    do_act = act_i && !ref_i && !pre_i;
    do_wr  = wr_i  && !ref_i && !pre_i && !act_i;
    do_rd  = rd_i  && !ref_i && !pre_i && !act_i && !wr_i;
  end

  assign err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state / counter update
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    main_cnt_d = sat_dec(main_cnt_q);
    ras_cnt_d  = sat_dec(ras_cnt_q);
    rtp_cnt_d  = sat_dec(rtp_cnt_q);
    wtp_cnt_d  = sat_dec(wtp_cnt_q);
    open_ra_d  = open_ra_q;

    // Timer-driven transitions when no row/refresh command overrides them.
    case (state_q)
      ST_OPENING: begin
        if (main_zero) begin
          state_d = ST_OPEN;
        end
      end
      ST_CLOSING, ST_REFRESHING: begin
        if (main_zero) begin
          state_d = ST_CLOSED;
        end
      end
      default: begin
      end
    endcase

    if (do_ref) begin
      state_d    = ST_REFRESHING;
      main_cnt_d = sat_dec(t_rfc);
    end else if (do_pre) begin
      state_d    = ST_CLOSING;
      main_cnt_d = sat_dec(t_rp);
    end else if (do_act) begin
      state_d    = ST_OPENING;
      main_cnt_d = sat_dec(t_rcd);
      ras_cnt_d  = sat_dec(t_ras);
      open_ra_d  = ra_i;
    end else if (do_wr) begin
      // Keep whichever write-to-precharge deadline ends later.
      wtp_cnt_d = cnt_max(sat_dec(wtp_cnt_q), sat_dec(t_wtp));
    end else if (do_rd) begin
      rtp_cnt_d = cnt_max(sat_dec(rtp_cnt_q), sat_dec(t_rtp));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLOSED;
      main_cnt_q <= '0;
      ras_cnt_q  <= '0;
      rtp_cnt_q  <= '0;
      wtp_cnt_q  <= '0;
      open_ra_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_cnt_q <= main_cnt_d;
      ras_cnt_q  <= ras_cnt_d;
      rtp_cnt_q  <= rtp_cnt_d;
      wtp_cnt_q  <= wtp_cnt_d;
      open_ra_q  <= open_ra_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign act_ok_o  = act_ok;
  assign ref_ok_o  = act_ok;
  assign rdwr_ok_o = rdwr_ok;
  assign pre_ok_o  = pre_ok;
  assign open_o    = (state_q == ST_OPENING) || (state_q == ST_OPEN);
  assign open_ra_o = open_ra_q;

endmodule

// File: tb/tb_sal_bank_timer.sv
module tb_sal_bank_timer;

  localparam int TW    = 8;
  localparam int ROW_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [TW-1:0]    t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic             act_i, rd_i, wr_i, pre_i, ref_i;
  logic [ROW_W-1:0] ra_i;
  logic             act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o, open_o, err_o;
  logic [ROW_W-1:0] open_ra_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sal_bank_timer #(.TW(TW), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .t_rcd     (t_rcd),
    .t_rp      (t_rp),
    .t_ras     (t_ras),
    .t_rfc     (t_rfc),
    .t_rtp     (t_rtp),
    .t_wtp     (t_wtp),
    .act_i     (act_i),
    .rd_i      (rd_i),
    .wr_i      (wr_i),
    .pre_i     (pre_i),
    .ref_i     (ref_i),
    .ra_i      (ra_i),
    .act_ok_o  (act_ok_o),
    .rdwr_ok_o (rdwr_ok_o),
    .pre_ok_o  (pre_ok_o),
    .ref_ok_o  (ref_ok_o),
    .open_o    (open_o),
    .open_ra_o (open_ra_o),
    .err_o     (err_o)
  );

  // -----------------------------------------------------------------------
  // Reference model: absolute cycle deadlines for every timing constraint.
  // -----------------------------------------------------------------------
  int               m_cyc;
  bit               m_open;
  logic [ROW_W-1:0] m_row;
  int               m_rdwr_at;   // first cycle RD/WR may issue
  int               m_openst_at; // first cycle the row counts as fully open
  int               m_ras_at;
  int               m_rtp_at;
  int               m_wtp_at;
  int               m_close_at;  // first cycle ACT/REF may issue

  function automatic int eff(input logic [TW-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  function automatic bit mdl_act_ok();
    return !m_open && (m_cyc >= m_close_at);
  endfunction

  function automatic bit mdl_rdwr_ok();
    return m_open && (m_cyc >= m_rdwr_at);
  endfunction

  function automatic bit mdl_pre_ok();
    return m_open && (m_cyc >= m_openst_at) && (m_cyc >= m_ras_at) &&
           (m_cyc >= m_rtp_at) && (m_cyc >= m_wtp_at);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_open = 0; m_row = '0;
    m_rdwr_at = 0; m_openst_at = 0; m_ras_at = 0;
    m_rtp_at = 0; m_wtp_at = 0; m_close_at = 0;
  endtask

  // kind: 0 act, 1 rd, 2 wr, 3 pre, 4 ref
  task automatic model_cmd(input int kind, input logic [ROW_W-1:0] ra);
    case (kind)
      0: begin
        m_open      = 1;
        m_row       = ra;
        m_rdwr_at   = m_cyc + eff(t_rcd);
        m_openst_at = m_rdwr_at + 1;
        m_ras_at    = m_cyc + eff(t_ras);
      end
      1: if (m_cyc + eff(t_rtp) > m_rtp_at) m_rtp_at = m_cyc + eff(t_rtp);
      2: if (m_cyc + eff(t_wtp) > m_wtp_at) m_wtp_at = m_cyc + eff(t_wtp);
      3: begin
        m_open     = 0;
        m_close_at = m_cyc + eff(t_rp);
      end
      default: m_close_at = m_cyc + eff(t_rfc);
    endcase
  endtask

  // -----------------------------------------------------------------------
  // Stimulus helpers (inputs change at negedge; outputs read at negedge)
  // -----------------------------------------------------------------------
  task automatic clear_cmds();
    act_i = 0; rd_i = 0; wr_i = 0; pre_i = 0; ref_i = 0; ra_i = '0;
  endtask

  task automatic do_reset();
    clear_cmds();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drive_cmd(input logic a, input logic r, input logic w,
                           input logic p, input logic f,
                           input logic [ROW_W-1:0] ra);
    act_i = a; rd_i = r; wr_i = w; pre_i = p; ref_i = f; ra_i = ra;
    @(negedge clk);
    clear_cmds();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spec_timing();
    t_rcd = 8'd4; t_rp = 8'd4; t_ras = 8'd12;
    t_rfc = 8'd26; t_rtp = 8'd2; t_wtp = 8'd9;
  endtask

  // -----------------------------------------------------------------------
  // Tests
  // -----------------------------------------------------------------------
  task automatic test_reset();
    spec_timing();
    clear_cmds();
    rst = 1;
    idle(2);
    checks++; if (act_ok_o !== 1'b1)   begin errors++; $display("FAIL rst_act_ok got %b exp 1", act_ok_o); end
    checks++; if (ref_ok_o !== 1'b1)   begin errors++; $display("FAIL rst_ref_ok got %b exp 1", ref_ok_o); end
    checks++; if (rdwr_ok_o !== 1'b0)  begin errors++; $display("FAIL rst_rdwr_ok got %b exp 0", rdwr_ok_o); end
    checks++; if (pre_ok_o !== 1'b0)   begin errors++; $display("FAIL rst_pre_ok got %b exp 0", pre_ok_o); end
    checks++; if (open_o !== 1'b0)     begin errors++; $display("FAIL rst_open got %b exp 0", open_o); end
    checks++; if (open_ra_o !== '0)    begin errors++; $display("FAIL rst_open_ra got %h exp 0", open_ra_o); end
    checks++; if (err_o !== 1'b0)      begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    rst = 0;
  endtask

  task automatic test_open_close();
    logic exp;
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h155);           // act@0
    for (int c = 1; c <= 15; c++) begin
      checks++; if (open_o !== 1'b1) begin errors++; $display("FAIL oc_open @%0d got %b exp 1", c, open_o); end
      checks++; if (open_ra_o !== 14'h155) begin errors++; $display("FAIL oc_open_ra @%0d got %h exp 155", c, open_ra_o); end
      exp = (c >= 4);
      checks++; if (rdwr_ok_o !== exp) begin errors++; $display("FAIL oc_rdwr_ok @%0d got %b exp %b", c, rdwr_ok_o, exp); end
      exp = (c >= 12);
      checks++; if (pre_ok_o !== exp) begin errors++; $display("FAIL oc_pre_ok @%0d got %b exp %b", c, pre_ok_o, exp); end
      checks++; if (act_ok_o !== 1'b0) begin errors++; $display("FAIL oc_act_ok @%0d got %b exp 0", c, act_ok_o); end
      if (c < 15) @(negedge clk);
    end
    drive_cmd(0, 0, 0, 1, 0, '0);                // pre@15
    for (int c = 16; c <= 20; c++) begin
      exp = (c >= 19);
      checks++; if (act_ok_o !== exp) begin errors++; $display("FAIL pc_act_ok @%0d got %b exp %b", c, act_ok_o, exp); end
      checks++; if (ref_ok_o !== exp) begin errors++; $display("FAIL pc_ref_ok @%0d got %b exp %b", c, ref_ok_o, exp); end
      checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL pc_open @%0d got %b exp 0", c, open_o); end
      checks++; if (open_ra_o !== 14'h155) begin errors++; $display("FAIL pc_open_ra @%0d got %h exp 155", c, open_ra_o); end
      if (c < 20) @(negedge clk);
    end
    drive_cmd(1, 0, 0, 0, 0, 14'h2AA);           // act@20
    checks++; if (open_o !== 1'b1) begin errors++; $display("FAIL react_open got %b exp 1", open_o); end
    checks++; if (open_ra_o !== 14'h2AA) begin errors++; $display("FAIL react_open_ra got %h exp 2aa", open_ra_o); end
    checks++; if (rdwr_ok_o !== 1'b0) begin errors++; $display("FAIL react_rdwr_ok got %b exp 0", rdwr_ok_o); end
  endtask

  task automatic test_rd_wr_to_pre();
    logic exp;
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h0011);          // act@0
    idle(3);
    drive_cmd(0, 1, 0, 0, 0, '0);                // rd@4
    for (int c = 5; c <= 13; c++) begin
      exp = (c >= 12);
      checks++; if (pre_ok_o !== exp) begin errors++; $display("FAIL rd_pre_ok @%0d got %b exp %b", c, pre_ok_o, exp); end
      @(negedge clk);
    end
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h0022);          // act@0
    idle(9);
    drive_cmd(0, 0, 1, 0, 0, '0);                // wr@10
    for (int c = 11; c <= 20; c++) begin
      exp = (c >= 19);
      checks++; if (pre_ok_o !== exp) begin errors++; $display("FAIL wr_pre_ok @%0d got %b exp %b", c, pre_ok_o, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_refresh();
    logic exp;
    do_reset();
    drive_cmd(0, 0, 0, 0, 1, '0);                // ref@0
    for (int c = 1; c <= 28; c++) begin
      exp = (c >= 26);
      checks++; if (act_ok_o !== exp) begin errors++; $display("FAIL ref_act_ok @%0d got %b exp %b", c, act_ok_o, exp); end
      checks++; if (ref_ok_o !== exp) begin errors++; $display("FAIL ref_ref_ok @%0d got %b exp %b", c, ref_ok_o, exp); end
      checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL ref_open @%0d got %b exp 0", c, open_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h3FFF);          // act@0
    idle(1);                                     // cycle 2: tRCD timer at 2
    #1 rst = 1;
    #1;
    checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL arst_open_async got %b exp 0", open_o); end
    checks++; if (act_ok_o !== 1'b1) begin errors++; $display("FAIL arst_act_ok_async got %b exp 1", act_ok_o); end
    #1 rst = 0;
    @(negedge clk);
    checks++; if (act_ok_o !== 1'b1) begin errors++; $display("FAIL arst_act_ok got %b exp 1", act_ok_o); end
    checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL arst_open got %b exp 0", open_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", err_o); end
    checks++; if (open_ra_o !== '0) begin errors++; $display("FAIL arst_open_ra got %h exp 0", open_ra_o); end
    checks++; if (rdwr_ok_o !== 1'b0) begin errors++; $display("FAIL arst_rdwr_ok got %b exp 0", rdwr_ok_o); end
  endtask

`ifdef SAL_BK_CMD_CHECK_EN
  task automatic test_cmd_check();
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h0100);          // act@0
    idle(1);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL chk_err_before got %b exp 0", err_o); end
    drive_cmd(0, 1, 0, 0, 0, '0);                // illegal rd@2
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL chk_err_set got %b exp 1", err_o); end
    checks++; if (rdwr_ok_o !== 1'b0) begin errors++; $display("FAIL chk_rdwr_ok3 got %b exp 0", rdwr_ok_o); end
    idle(1);
    checks++; if (rdwr_ok_o !== 1'b1) begin errors++; $display("FAIL chk_rdwr_ok4 got %b exp 1", rdwr_ok_o); end
    idle(5);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL chk_err_held got %b exp 1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL chk_err_clr got %b exp 0", err_o); end
    drive_cmd(1, 0, 0, 0, 1, 14'h0200);          // act+ref together
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL chk_multi_err got %b exp 1", err_o); end
    checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL chk_multi_open got %b exp 0", open_o); end
    checks++; if (act_ok_o !== 1'b1) begin errors++; $display("FAIL chk_multi_act_ok got %b exp 1", act_ok_o); end
  endtask
`else
  task automatic test_priority();
    logic exp;
    do_reset();
    drive_cmd(1, 0, 0, 0, 1, 14'h0300);          // act+ref: ref wins
    checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL pri_actref_open got %b exp 0", open_o); end
    checks++; if (act_ok_o !== 1'b0) begin errors++; $display("FAIL pri_actref_act_ok got %b exp 0", act_ok_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL pri_err got %b exp 0", err_o); end
    do_reset();
    drive_cmd(1, 1, 0, 0, 0, 14'h0301);          // act+rd: act wins
    checks++; if (open_o !== 1'b1) begin errors++; $display("FAIL pri_actrd_open got %b exp 1", open_o); end
    checks++; if (open_ra_o !== 14'h0301) begin errors++; $display("FAIL pri_actrd_ra got %h exp 0301", open_ra_o); end
    idle(11);                                    // cycle 12, pre legal
    drive_cmd(1, 0, 0, 1, 0, 14'h0302);          // pre+act: pre wins
    checks++; if (open_o !== 1'b0) begin errors++; $display("FAIL pri_preact_open got %b exp 0", open_o); end
    checks++; if (act_ok_o !== 1'b0) begin errors++; $display("FAIL pri_preact_act_ok got %b exp 0", act_ok_o); end
    do_reset();
    drive_cmd(1, 0, 0, 0, 0, 14'h0303);
    idle(11);
    drive_cmd(0, 1, 1, 0, 0, '0);                // rd+wr@12: wr wins
    for (int c = 13; c <= 21; c++) begin
      exp = (c >= 21);
      checks++; if (pre_ok_o !== exp) begin errors++; $display("FAIL pri_wrrd_pre_ok @%0d got %b exp %b", c, pre_ok_o, exp); end
      if (c < 21) @(negedge clk);
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0]       legal;
    logic [ROW_W-1:0] ra;
    int               kind, k;
    for (int round = 0; round < 6; round++) begin
      t_rcd = TW'($urandom_range(0, 6));
      t_rp  = TW'($urandom_range(0, 6));
      t_ras = TW'($urandom_range(0, 15));
      t_rfc = TW'($urandom_range(0, 20));
      t_rtp = TW'($urandom_range(0, 5));
      t_wtp = TW'($urandom_range(0, 12));
      do_reset();
      model_reset();
      for (int n = 0; n < 400; n++) begin
        checks++; if (act_ok_o !== mdl_act_ok()) begin errors++; $display("FAIL rnd_act_ok r%0d @%0d got %b exp %b", round, m_cyc, act_ok_o, mdl_act_ok()); end
        checks++; if (ref_ok_o !== mdl_act_ok()) begin errors++; $display("FAIL rnd_ref_ok r%0d @%0d got %b exp %b", round, m_cyc, ref_ok_o, mdl_act_ok()); end
        checks++; if (rdwr_ok_o !== mdl_rdwr_ok()) begin errors++; $display("FAIL rnd_rdwr_ok r%0d @%0d got %b exp %b", round, m_cyc, rdwr_ok_o, mdl_rdwr_ok()); end
        checks++; if (pre_ok_o !== mdl_pre_ok()) begin errors++; $display("FAIL rnd_pre_ok r%0d @%0d got %b exp %b", round, m_cyc, pre_ok_o, mdl_pre_ok()); end
        checks++; if (open_o !== m_open) begin errors++; $display("FAIL rnd_open r%0d @%0d got %b exp %b", round, m_cyc, open_o, m_open); end
        checks++; if (open_ra_o !== m_row) begin errors++; $display("FAIL rnd_open_ra r%0d @%0d got %h exp %h", round, m_cyc, open_ra_o, m_row); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err r%0d @%0d got %b exp 0", round, m_cyc, err_o); end
        legal = {mdl_act_ok(), mdl_pre_ok(), mdl_rdwr_ok(), mdl_rdwr_ok(), mdl_act_ok()};
        kind  = -1;
        if (legal != '0 && $urandom_range(0, 99) < 45) begin
          k = int'($urandom_range(0, 4));
          for (int j = 0; j < 5; j++) begin
            if (kind < 0 && legal[(k + j) % 5]) kind = (k + j) % 5;
          end
        end
        ra = ROW_W'($urandom);
        if (kind >= 0) begin
          model_cmd(kind, ra);
          drive_cmd(kind == 0, kind == 1, kind == 2, kind == 3, kind == 4, ra);
        end else begin
          @(negedge clk);
        end
        m_cyc++;
      end
    end
  endtask

  initial begin
    clear_cmds();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_open_close();
    test_rd_wr_to_pre();
    test_refresh();
    test_async_reset();
`ifdef SAL_BK_CMD_CHECK_EN
    test_cmd_check();
`else
    test_priority();
`endif
    spec_timing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
